// File: rtl/mac_pkg.sv
// Shared types and helpers for the pipelined approximate MAC: accumulator
// width, stage-2 FSM state encoding and the approximate-product mask.
package mac_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } acc_state_e;

  function automatic int acc_width(input int w, input int guard);
    return 2 * w + guard;
  endfunction

  // Product-width mask with the low approx_lsb bits cleared; callers slice to 2*w bits.
  function automatic logic [63:0] approx_mask(input int w, input int approx_lsb);
    return (~64'd0 << approx_lsb) & (~64'd0 >> (64 - 2 * w));
  endfunction

endpackage

// File: rtl/approx_mul.sv
// Combinational unsigned multiplier whose low APPROX_LSB product bits are
// forced to zero; the parent registers the result in pipeline stage 1.
module approx_mul
  import mac_pkg::*;
#(
  parameter int W          = 16,
  parameter int APPROX_LSB = 5
) (
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic [2*W-1:0] o_p
);

  localparam logic [63:0]    MASK64 = approx_mask(W, APPROX_LSB);
  localparam logic [2*W-1:0] MASK   = MASK64[2*W-1:0];

  logic [2*W-1:0] w_full;

  assign w_full = {{W{1'b0}}, i_a} * {{W{1'b0}}, i_b};
  assign o_p    = w_full & MASK;

endmodule

// File: rtl/mac_pipe_acc.sv
// Two-stage pipelined approximate MAC with single and group-accumulate modes.
// Define MAC_PIPE_ACC_SAT_EN to saturate the result on overflow instead of wrapping.
module mac_pipe_acc
  import mac_pkg::*;
#(
  parameter int  W          = 16,
  parameter int  APPROX_LSB = 5,
  parameter int  GUARD      = 4,
  localparam int ACC_W      = acc_width(W, GUARD)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [W-1:0]     c,
  input  logic             mode,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] r,
  output logic             ovf
);

  // state    | meaning
  // ST_IDLE  | no group open; next stage-1 beat is a single op or a group seed
  // ST_ACCUM | group open; stage-1 beats add their product to the accumulator

  logic             w_adv;
  logic [2*W-1:0]   w_p;

  logic             r_s1_valid;
  logic [2*W-1:0]   r_s1_p;
  logic [W-1:0]     r_s1_c;
  logic             r_s1_mode;
  logic             r_s1_last;

  acc_state_e       r_state, w_state_nxt;
  logic [ACC_W-1:0] r_acc, w_acc_nxt;
  logic             r_acc_ovf, w_acc_ovf_nxt;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_r, w_r_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             w_emit;

  logic [ACC_W-1:0] w_base;
  logic [ACC_W:0]   w_sum;
  logic             w_ovf_grp;
  logic [ACC_W-1:0] w_res;

  assign w_adv     = ~r_out_valid | out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_out_valid;
  assign r         = r_r;
  assign ovf       = r_ovf;

  approx_mul #(
    .W          (W),
    .APPROX_LSB (APPROX_LSB)
  ) u_approx_mul (
    .i_a (a),
    .i_b (b),
    .o_p (w_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_p     <= '0;
      r_s1_c     <= '0;
      r_s1_mode  <= 1'b0;
      r_s1_last  <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_p    <= w_p;
        r_s1_c    <= c;
        r_s1_mode <= mode;
        r_s1_last <= in_last;
      end
    end
  end

  // A group seed adds c; a beat inside a group adds to the running sum.
  assign w_base    = (r_state == ST_IDLE) ? ACC_W'(r_s1_c) : r_acc;
  assign w_sum     = (ACC_W + 1)'(w_base) + (ACC_W + 1)'(r_s1_p);
  assign w_ovf_grp = w_sum[ACC_W] | ((r_state == ST_ACCUM) & r_acc_ovf);

`ifdef MAC_PIPE_ACC_SAT_EN
  assign w_res = w_ovf_grp ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
  assign w_res = w_sum[ACC_W-1:0];
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_acc_nxt     = r_acc;
    w_acc_ovf_nxt = r_acc_ovf;
    w_r_nxt       = r_r;
    w_ovf_nxt     = r_ovf;
    w_emit        = 1'b0;
    if (r_s1_valid) begin
      unique case (r_state)
        ST_IDLE: begin
          if (!r_s1_mode) begin
            w_emit    = 1'b1;
            w_r_nxt   = w_res;
            w_ovf_nxt = w_ovf_grp;
          end else begin
            w_acc_nxt     = w_res;
            w_acc_ovf_nxt = w_ovf_grp;
            if (r_s1_last) begin
              w_emit    = 1'b1;
              w_r_nxt   = w_res;
              w_ovf_nxt = w_ovf_grp;
            end else begin
              w_state_nxt = ST_ACCUM;
            end
          end
        end
        ST_ACCUM: begin
          w_acc_nxt     = w_res;
          w_acc_ovf_nxt = w_ovf_grp;
          if (r_s1_last) begin
            w_emit      = 1'b1;
            w_r_nxt     = w_res;
            w_ovf_nxt   = w_ovf_grp;
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_acc_ovf   <= 1'b0;
      r_out_valid <= 1'b0;
      r_r         <= '0;
      r_ovf       <= 1'b0;
    end else if (w_adv) begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_acc_ovf   <= w_acc_ovf_nxt;
      r_out_valid <= w_emit;
      r_r         <= w_r_nxt;
      r_ovf       <= w_ovf_nxt;
    end
  end

endmodule

// File: tb/tb_mac_pipe_acc.sv
// Self-checking bench for mac_pipe_acc: directed scenarios plus a randomized
// run against an arithmetic reference model (honours MAC_PIPE_ACC_SAT_EN).
module tb_mac_pipe_acc;

  localparam int W          = 16;
  localparam int APPROX_LSB = 5;
  localparam int GUARD      = 4;
  localparam int ACC_W      = 36;
  localparam longint unsigned ACC_MOD = 64'd1 << ACC_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     a = '0, b = '0, c = '0;
  logic             mode = 1'b0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ACC_W-1:0] r;
  logic             ovf;

  int n_chk  = 0;
  int n_fail = 0;

  mac_pipe_acc #(
    .W          (W),
    .APPROX_LSB (APPROX_LSB),
    .GUARD      (GUARD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .mode      (mode),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Exact product rounded down to a multiple of 2^APPROX_LSB.
  function automatic longint unsigned prod(input logic [W-1:0] x, input logic [W-1:0] y);
    longint unsigned f;
    f = 64'(x) * 64'(y);
    return f - (f % 64'd32);
  endfunction

  // Turns an exact group total into the expected (r, ovf) pair.
  function automatic void model_result(input longint unsigned total,
                                       output logic [ACC_W-1:0] er, output logic eo);
    eo = (total >= ACC_MOD);
`ifdef MAC_PIPE_ACC_SAT_EN
    er = eo ? {ACC_W{1'b1}} : ACC_W'(total);
`else
    er = ACC_W'(total % ACC_MOD);
`endif
  endfunction

  task automatic idle_inputs();
    in_valid = 1'b0; a = '0; b = '0; c = '0; mode = 1'b0; in_last = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                      input logic [W-1:0] tc, input logic tm, input logic tl);
    int k;
    @(negedge clk);
    a = ta; b = tb; c = tc; mode = tm; in_last = tl; in_valid = 1'b1;
    #1;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk); #1;
      k++;
    end
    n_chk++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL send_accept: in_ready=%0b after %0d cycles, required 1", in_ready, k);
    end
    @(posedge clk);
  endtask

  task automatic wait_out(output bit got);
    int k;
    @(negedge clk);
    idle_inputs();
    #1;
    k = 0;
    while (!out_valid && k < 60) begin
      @(negedge clk); #1;
      k++;
    end
    got = out_valid;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; idle_inputs(); out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || r !== '0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: out_valid=%0b r=%h ovf=%0b, required 0 0 0", out_valid, r, ovf);
    end
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %0b required 1", in_ready);
    end
    do_reset();
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset: out_valid=%0b in_ready=%0b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_single_latency();
    send(16'd3, 16'd5, 16'd7, 1'b0, 1'b0);
    @(negedge clk);
    idle_inputs();
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_edge1: out_valid=%0b required 0", out_valid);
    end
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b1 || r !== 36'd7 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_edge2: out_valid=%0b r=%0d ovf=%0b, required 1 7 0", out_valid, r, ovf);
    end
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_no_dup: out_valid=%0b required 0", out_valid);
    end
  endtask

  task automatic test_single_max();
    bit got;
    send(16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    wait_out(got);
    n_chk++;
    if (!got || r !== 36'h0FFFEFFFF || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL single_max: valid=%0b r=%h ovf=%0b, required 1 0fffeffff 0", got, r, ovf);
    end
  endtask

  task automatic test_accum();
    bit got;
    for (int i = 0; i < 4; i++) begin
      send(16'd256, 16'd256, (i == 0) ? 16'd10 : 16'd999, 1'b1, (i == 3));
      #1;
      n_chk++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL accum_no_early_out: beat %0d out_valid=%0b required 0", i, out_valid);
      end
    end
    wait_out(got);
    n_chk++;
    if (!got || r !== 36'd262154 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL accum_result: valid=%0b r=%0d ovf=%0b, required 1 262154 0", got, r, ovf);
    end
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL accum_single_out: out_valid=%0b required 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    bit got;
    logic [W-1:0] a1, b1, c1, a2, b2, c2;
    logic [ACC_W-1:0] e1, e2;
    logic o1, o2;
    a1 = 16'($urandom); b1 = 16'($urandom); c1 = 16'($urandom);
    a2 = 16'($urandom); b2 = 16'($urandom); c2 = 16'($urandom);
    model_result(prod(a1, b1) + 64'(c1), e1, o1);
    model_result(prod(a2, b2) + 64'(c2), e2, o2);
    out_ready = 1'b0;
    send(a1, b1, c1, 1'b0, 1'b0);
    wait_out(got);
    a = a2; b = b2; c = c2; mode = 1'b0; in_last = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_chk++;
      if (!got || out_valid !== 1'b1 || r !== e1 || ovf !== o1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold: cycle %0d out_valid=%0b r=%h in_ready=%0b, required 1 %h 0",
                 i, out_valid, r, in_ready, e1);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_no_dup: out_valid=%0b required 0", out_valid);
    end
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b1 || r !== e2 || ovf !== o2) begin
      n_fail++;
      $display("FAIL bp_second: out_valid=%0b r=%h ovf=%0b, required 1 %h %0b", out_valid, r, ovf, e2, o2);
    end
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: out_valid=%0b required 0", out_valid);
    end
  endtask

  task automatic test_overflow();
    bit got;
    longint unsigned total;
    logic [ACC_W-1:0] er;
    logic eo;
    total = 0;
    for (int i = 0; i < 20; i++) begin
      send(16'hFFFF, 16'hFFFF, 16'd0, 1'b1, (i == 19));
      total += prod(16'hFFFF, 16'hFFFF);
    end
    model_result(total, er, eo);
    wait_out(got);
    n_chk++;
    if (!got || r !== er || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow: valid=%0b r=%h ovf=%0b, required 1 %h 1", got, r, ovf, er);
    end
    send(16'd2, 16'd100, 16'd3, 1'b1, 1'b0);
    send(16'd4, 16'd100, 16'd0, 1'b1, 1'b1);
    wait_out(got);
    n_chk++;
    if (!got || r !== 36'd579 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_cleared: valid=%0b r=%0d ovf=%0b, required 1 579 0", got, r, ovf);
    end
  endtask

  task automatic test_reset_midgroup();
    bit got;
    send(16'd1000, 16'd1000, 16'd55, 1'b1, 1'b0);
    send(16'd1000, 16'd1000, 16'd0, 1'b1, 1'b0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || r !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_midgroup: out_valid=%0b r=%h in_ready=%0b, required 0 0 1", out_valid, r, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(16'd1, 16'd1, 16'd1, 1'b0, 1'b0);
    wait_out(got);
    n_chk++;
    if (!got || r !== 36'd1 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_no_stale: valid=%0b r=%h ovf=%0b, required 1 1 0", got, r, ovf);
    end
  endtask

  task automatic test_random();
    logic [ACC_W-1:0] q_r[$];
    logic             q_o[$];
    logic [ACC_W-1:0] er, exp_r;
    logic             eo, exp_o;
    longint unsigned  acc;
    bit grp_open, pending;
    int accepted, cyc;
    acc = 0; grp_open = 0; pending = 0; accepted = 0; cyc = 0;
    while ((accepted < 150 || grp_open || q_r.size() > 0) && cyc < 5000) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      if (!pending) begin
        if (accepted < 150 || grp_open) begin
          in_valid = ($urandom_range(0, 4) != 0);
          a = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hF000, 16'hFFFF)) : 16'($urandom);
          b = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hF000, 16'hFFFF)) : 16'($urandom);
          c = 16'($urandom);
          mode = 1'($urandom_range(0, 1));
          in_last = (accepted >= 150) ? 1'b1 : ($urandom_range(0, 2) == 0);
        end else begin
          idle_inputs();
        end
      end
      #1;
      if (out_valid && out_ready) begin
        n_chk++;
        if (q_r.size() == 0) begin
          n_fail++;
          $display("FAIL rand_spurious: unexpected result r=%h ovf=%0b", r, ovf);
        end else begin
          exp_r = q_r.pop_front();
          exp_o = q_o.pop_front();
          if (r !== exp_r || ovf !== exp_o) begin
            n_fail++;
            $display("FAIL rand_result: r=%h ovf=%0b, required %h %0b", r, ovf, exp_r, exp_o);
          end
        end
      end
      if (in_valid && in_ready) begin
        accepted++;
        pending = 0;
        if (!grp_open) begin
          acc = prod(a, b) + 64'(c);
          if (!mode || in_last) begin
            model_result(acc, er, eo);
            q_r.push_back(er); q_o.push_back(eo);
          end else begin
            grp_open = 1;
          end
        end else begin
          acc += prod(a, b);
          if (in_last) begin
            model_result(acc, er, eo);
            q_r.push_back(er); q_o.push_back(eo);
            grp_open = 0;
          end
        end
      end else begin
        pending = in_valid;
      end
      cyc++;
    end
    @(negedge clk);
    idle_inputs();
    out_ready = 1'b1;
    n_chk++;
    if (q_r.size() != 0 || cyc >= 5000) begin
      n_fail++;
      $display("FAIL rand_drain: %0d results outstanding after %0d cycles, required 0", q_r.size(), cyc);
    end
  endtask

  initial begin
    test_reset();
    test_single_latency();
    test_single_max();
    test_accum();
    test_backpressure();
    test_overflow();
    test_reset_midgroup();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
